imem_responder: RTL
===================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
Parameters:
REQ-001 SHALL provide parameter DEPTH_WORDS, default 256, meaning the number of 32-bit instruction words; power of two, 4..4096.
REQ-002 SHALL provide parameter LATENCY, default 1, meaning wait cycles between request accept and response; legal range 0..15.
Ports (reset: synchronous, active-high; clock: clk):
REQ-003 SHALL provide port: clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port: req_valid  input  1  fetch request from the PC stage is present.
REQ-006 SHALL provide port: req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL provide port: req_addr  input  32  byte address of the instruction (the PC value).
REQ-008 SHALL provide port: rsp_valid  output  1  response word is present.
REQ-009 SHALL provide port: rsp_ready  input  1  consumer accepts the response this cycle.
REQ-010 SHALL provide port: rsp_instr  output  32  fetched instruction word.
REQ-011 SHALL provide port: rsp_err  output  1  request was misaligned or out of range.
REQ-012 SHALL provide port: ld_we  input  1  load-port write enable for program preload.
REQ-013 SHALL provide port: ld_addr  input  32  load-port byte address.
REQ-014 SHALL provide port: ld_data  input  32  load-port write data.
REQ-015 SHALL provide port: busy  output  1  a transaction is in flight (state != IDLE).

Function
REQ-016 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready = 1 only in IDLE; only one transaction is outstanding at a time.
REQ-018 SHALL accept a request on a rising edge where req_valid && req_ready, latching req_addr internally.
REQ-019 On accept, SHALL go to RESP if LATENCY == 0; otherwise it SHALL go to WAIT with the wait counter loaded with LATENCY.
REQ-020 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-021 Timing: if accept occurs at edge N, rsp_valid SHALL first be high in the cycle following edge N+LATENCY.
REQ-022 SHALL register rsp_instr and rsp_err on the edge entering RESP.
REQ-023 In RESP, SHALL hold rsp_valid = 1 and keep rsp_instr and rsp_err stable until rsp_valid && rsp_ready.
REQ-024 On the response handshake edge, SHALL return to IDLE and deassert rsp_valid; a new request can be accepted no earlier than the next edge.
REQ-025 Peak throughput SHALL be one fetch per LATENCY+2 cycles.
REQ-026 SHALL compute the word index as req_addr[log2(DEPTH_WORDS)+1:2].
REQ-027 An address is in range iff req_addr < 4*DEPTH_WORDS.
REQ-028 If req_addr[1:0] != 0 or the address is out of range, SHALL return rsp_err = 1 and rsp_instr = 32'h00000013 (NOP); otherwise rsp_err = 0 and rsp_instr = the stored word.
REQ-029 SHALL write ld_data to the addressed word on an edge where ld_we = 1, ld_addr is aligned and in range; it SHALL ignore the write otherwise, with no error signalled.
REQ-030 The load port SHALL be usable in any state.
REQ-031 If a load write and the RESP-entry capture target the same word on the same edge, SHALL return the old (pre-write) contents.
REQ-032 rsp_ready asserted while rsp_valid = 0 SHALL have no effect.
REQ-033 req_valid while req_ready = 0 SHALL be ignored; the requester holds it.

Reset
REQ-034 When reset = 1 at a rising edge, SHALL enter IDLE, clear the wait counter, and set rsp_valid = 0, rsp_instr = 32'h0, rsp_err = 0, busy = 0.
REQ-035 req_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-036 Reset during WAIT or RESP SHALL abort the transaction; no response is ever issued for it.
REQ-037 Reset SHALL take priority over any simultaneous handshake or load write to control state.
REQ-038 Memory contents SHALL NOT be cleared by reset; never-written words are undefined.

Verification
REQ-039 LATENCY=1: preload word 0 = 32'h00500093, request 0x0 at edge N, rsp_ready=1 -> rsp_valid high after edge N+1, rsp_instr=32'h00500093, rsp_err=0, req_ready=1 after edge N+2.
REQ-040 LATENCY=0: load 0x4=32'hFFDFF06F, request 0x4 -> rsp_valid high the cycle after accept with that word.
REQ-041 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_instr, rsp_err stable; req_ready=0 throughout; completes on rsp_ready=1.
REQ-042 Errors: request 0x2 -> rsp_err=1, rsp_instr=32'h00000013; with DEPTH_WORDS=256, request 0x400 -> rsp_err=1.
REQ-043 Reset mid-WAIT (LATENCY=3) -> no rsp_valid; next request 0x8 completes normally with the preloaded data intact.
REQ-044 Same-edge collision: load 0x8 on the RESP-entry edge of a read of 0x8 -> old value returned, new value on the next read.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: single-outstanding instruction memory with a valid/ready fetch port,
// a configurable response latency and a side load port for program preload.
//
// Ports:
//   clk, reset      - clock (rising edge) and synchronous active-high reset
//   req_valid/ready - fetch request handshake; req_addr is the byte PC
//   rsp_valid/ready - response handshake; rsp_instr word, rsp_err misaligned/out of range
//   ld_we/addr/data - preload write port, usable in any state
//   busy            - a transaction is in flight
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        busy
);

  localparam int unsigned Aw      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam logic [3:0]  LatInit = 4'(LATENCY);

  typedef enum logic [1:0] {StIdle = 2'd0, StWait = 2'd1, StResp = 2'd2} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [3:0]      r_cnt;
  logic [31:0]     r_addr;
  logic [31:0]     r_instr;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic            w_enter_resp;
  logic [31:0]     w_cap_addr;
  logic            w_cap_ok;
  logic [Aw-1:0]   w_cap_idx;
  logic            w_ld_ok;
  logic [Aw-1:0]   w_ld_idx;

  assign w_accept     = req_valid && (r_state == StIdle);
  assign w_enter_resp = (w_state_next == StResp) && (r_state != StResp);

  // With zero latency RESP is entered on the accept edge, so capture straight from req_addr.
  assign w_cap_addr = (r_state == StIdle) ? req_addr : r_addr;
  assign w_cap_ok   = (w_cap_addr[1:0] == 2'b00) && (w_cap_addr[31:Aw+2] == '0);
  assign w_cap_idx  = w_cap_addr[Aw+1:2];

  assign w_ld_ok  = (ld_addr[1:0] == 2'b00) && (ld_addr[31:Aw+2] == '0);
  assign w_ld_idx = ld_addr[Aw+1:2];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_state_next = (LATENCY == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (r_cnt == 4'd1) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (r_state == StIdle);
    rsp_valid = (r_state == StResp);
    busy      = (r_state != StIdle);
    rsp_instr = r_instr;
    rsp_err   = r_err;
  end

  // Wait counter and latched request address
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= 4'd0;
      r_addr <= 32'h0;
    end else if (w_accept) begin
      r_cnt  <= LatInit;
      r_addr <= req_addr;
    end else if (r_state == StWait) begin
      r_cnt  <= r_cnt - 4'd1;
    end
  end

  // Response capture; reads the array before this edge's load write lands (old data wins).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= 32'h0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      if (w_cap_ok) begin
        r_instr <= r_mem[w_cap_idx];
        r_err   <= 1'b0;
      end else begin
        r_instr <= Nop;
        r_err   <= 1'b1;
      end
    end
  end

  // Storage is never reset.
  always_ff @(posedge clk) begin
    if (ld_we && w_ld_ok) begin
      r_mem[w_ld_idx] <= ld_data;
    end
  end

endmodule
